// File: rtl/move_input_ctrl_pkg.sv
// Shared definitions for the frog movement input front end.
// Holds the default timing constants, the direction encoding, the FSM state
// encoding and two small helpers for priority arbitration and one-hot
// pulse generation.
package move_input_ctrl_pkg;

  // Defaults assume a 25 MHz system clock.
  localparam int c_DEBOUNCE_LIMIT = 250000;    // 10 ms
  localparam int c_REPEAT_DELAY   = 12500000;  // 500 ms to the first repeat
  localparam int c_REPEAT_PERIOD  = 5000000;   // 200 ms between repeats
  localparam int c_CNT_WIDTH      = 24;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  // Fixed priority Up > Down > Left > Right. Bit n of pressed is direction n.
  function automatic dir_e pick_dir(input logic [3:0] pressed);
    if (pressed[DIR_UP])        return DIR_UP;
    else if (pressed[DIR_DOWN]) return DIR_DOWN;
    else if (pressed[DIR_LEFT]) return DIR_LEFT;
    else                        return DIR_RIGHT;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_e d);
    return 4'(4'b0001 << d);
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Switch / movement-pulse bundle between the board switches, the input
// front end and the frog controller.
//   i_Switch_1..4 : raw Up/Down/Left/Right switches (asynchronous)
//   i_Enable      : movement allowed
//   o_*_Mvt       : one-cycle movement pulses
//   o_Held        : a direction is currently latched
// master drives the switches and enable; slave is the front end itself.
interface move_input_ctrl_if;
  logic i_Switch_1;
  logic i_Switch_2;
  logic i_Switch_3;
  logic i_Switch_4;
  logic i_Enable;
  logic o_Up_Mvt;
  logic o_Down_Mvt;
  logic o_Left_Mvt;
  logic o_Right_Mvt;
  logic o_Held;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4, i_Enable,
    input  o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Held
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4, i_Enable,
    output o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Held
  );
endinterface

// File: rtl/move_input_ctrl_debounce.sv
// switch_debounce: conditions one raw board switch.
// A 2-FF synchroniser feeds a stability counter; the debounced state only
// flips after the synced input has disagreed with it for c_DEBOUNCE_LIMIT
// consecutive cycles. Raw edge to o_State change is 2 + c_DEBOUNCE_LIMIT.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_Switch       : raw switch, asynchronous to i_Clk
//   o_State        : debounced switch state
module switch_debounce #(
  parameter int c_DEBOUNCE_LIMIT = move_input_ctrl_pkg::c_DEBOUNCE_LIMIT,
  parameter int c_CNT_WIDTH      = move_input_ctrl_pkg::c_CNT_WIDTH
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_State
);

  localparam logic [c_CNT_WIDTH-1:0] c_LAST = c_CNT_WIDTH'(c_DEBOUNCE_LIMIT - 1);

  logic                   sync1_q, sync2_q;
  logic                   state_q, state_d;
  logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;  // any agreement restarts the stability window
    if (sync2_q != state_q) begin
      if (cnt_q == c_LAST) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value; blocking here would collapse the synchroniser to one stage.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_State = state_q;

endmodule

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: frog movement input front end.
// Debounces the four board switches, arbitrates one direction with
// Up > Down > Left > Right priority and issues registered one-cycle pulses
// with hold-to-repeat (first repeat after c_REPEAT_DELAY, then every
// c_REPEAT_PERIOD). The latched direction owns the FSM until it releases.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   bus (slave)    : switches, enable, movement pulses, held flag
module move_input_ctrl #(
  parameter int c_DEBOUNCE_LIMIT = move_input_ctrl_pkg::c_DEBOUNCE_LIMIT,
  parameter int c_REPEAT_DELAY   = move_input_ctrl_pkg::c_REPEAT_DELAY,
  parameter int c_REPEAT_PERIOD  = move_input_ctrl_pkg::c_REPEAT_PERIOD,
  parameter int c_CNT_WIDTH      = move_input_ctrl_pkg::c_CNT_WIDTH
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  move_input_ctrl_if.slave   bus
);
  import move_input_ctrl_pkg::*;

  localparam logic [c_CNT_WIDTH-1:0] c_DELAY_LAST  = c_CNT_WIDTH'(c_REPEAT_DELAY - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_PERIOD_LAST = c_CNT_WIDTH'(c_REPEAT_PERIOD - 1);

  logic [3:0] raw_sw;
  logic [3:0] db_sw;

  assign raw_sw = {bus.i_Switch_4, bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};

  for (genvar g = 0; g < 4; g++) begin : g_db
    switch_debounce #(
      .c_DEBOUNCE_LIMIT (c_DEBOUNCE_LIMIT),
      .c_CNT_WIDTH      (c_CNT_WIDTH)
    ) u_db (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Switch (raw_sw[g]),
      .o_State  (db_sw[g])
    );
  end

  logic [1:0]             state_q, state_d;
  dir_e                   dir_q, dir_d;
  logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]             mvt_q, mvt_d;
  logic                   keep;

  // Stay armed only while the latched switch is still down and movement is
  // allowed; this check runs before the counter so a release on the repeat
  // cycle suppresses the pulse.
  assign keep = db_sw[dir_q] && bus.i_Enable;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    mvt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_Enable && (|db_sw)) begin
          dir_d   = pick_dir(db_sw);
          mvt_d   = dir_onehot(dir_d);
          cnt_d   = '0;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!keep) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == c_DELAY_LAST) begin
          mvt_d   = dir_onehot(dir_q);
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!keep) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == c_PERIOD_LAST) begin
          mvt_d = dir_onehot(dir_q);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      mvt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      mvt_q   <= mvt_d;
    end
  end

  // Pulses come straight from flops so the controller's edge detector sees
  // clean one-cycle highs; repeat delay/period >= 2 guarantees a low gap.
  assign bus.o_Up_Mvt    = mvt_q[DIR_UP];
  assign bus.o_Down_Mvt  = mvt_q[DIR_DOWN];
  assign bus.o_Left_Mvt  = mvt_q[DIR_LEFT];
  assign bus.o_Right_Mvt = mvt_q[DIR_RIGHT];
  assign bus.o_Held      = (state_q != S_IDLE);

endmodule
